// File: rtl/fb_scanout_reader.sv
// ---------------------------------------------------------------------------
// fb_scanout_reader
//   Reads one FB_WIDTH x FB_HEIGHT frame in raster order from a synchronous
//   fixed-latency framebuffer RAM. The pixels go out as a valid/ready stream
//   tagged with start-of-frame and end-of-line. A small output FIFO absorbs the
//   RAM latency. A read is issued only while FIFO occupancy plus reads in
//   flight is below FIFO_DEPTH. Every returning word therefore has a FIFO
//   slot, and backpressure never drops read data.
//
// Ports
//   clk, rst         clock; asynchronous active-high reset
//   frame_start      pulse that starts a frame (honoured only when idle)
//   buffer_sel       front buffer select, latched at frame start
//   fb_read_addr     RAM read address (0 when not strobing)
//   fb_read_enable   RAM read strobe
//   fb_read_data     RAM data, READ_LATENCY cycles after the strobe
//   pixel_data       stream pixel (FIFO head)
//   pixel_valid      stream valid (FIFO not empty)
//   pixel_ready      stream ready; a transfer happens on valid && ready
//   pixel_sof        head pixel is (0,0)
//   pixel_eol        head pixel is the last one of its line
//   busy             frame in progress
//   frame_done       one-cycle pulse after the last pixel has transferred
// ---------------------------------------------------------------------------
module fb_scanout_reader #(
    parameter int FB_WIDTH      = 160,
    parameter int FB_HEIGHT     = 120,
    parameter int FB_ADDR_WIDTH = 16,
    parameter int COLOR_WIDTH   = 12,
    parameter int READ_LATENCY  = 1,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_start,
    input  logic                     buffer_sel,
    output logic [FB_ADDR_WIDTH-1:0] fb_read_addr,
    output logic                     fb_read_enable,
    input  logic [COLOR_WIDTH-1:0]   fb_read_data,
    output logic [COLOR_WIDTH-1:0]   pixel_data,
    output logic                     pixel_valid,
    input  logic                     pixel_ready,
    output logic                     pixel_sof,
    output logic                     pixel_eol,
    output logic                     busy,
    output logic                     frame_done
);

    localparam int XW = (FB_WIDTH > 1) ? $clog2(FB_WIDTH) : 1;
    localparam int YW = (FB_HEIGHT > 1) ? $clog2(FB_HEIGHT) : 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [XW-1:0]            X_LAST    = XW'(FB_WIDTH - 1);
    localparam logic [YW-1:0]            Y_LAST    = YW'(FB_HEIGHT - 1);
    localparam logic [PW-1:0]            PTR_LAST  = PW'(FIFO_DEPTH - 1);
    localparam logic [CW:0]              DEPTH_C   = (CW + 1)'(FIFO_DEPTH);
    localparam logic [FB_ADDR_WIDTH-1:0] BUF1_BASE = FB_ADDR_WIDTH'(FB_WIDTH * FB_HEIGHT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN
    } state_t;

    state_t state, state_nxt;

    logic [FB_ADDR_WIDTH-1:0] addr;
    logic [XW-1:0]            x;
    logic [YW-1:0]            y;
    logic [CW-1:0]            fifo_count;
    logic [CW-1:0]            inflight;

    // Strobe and tags travel alongside the RAM access. The last stage marks
    // the cycle in which fb_read_data holds the matching word.
    logic [READ_LATENCY-1:0]  vld_pipe;
    logic [READ_LATENCY-1:0]  sof_pipe;
    logic [READ_LATENCY-1:0]  eol_pipe;

    // FIFO entry layout: {sof, eol, data}
    logic [COLOR_WIDTH+1:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]            wr_ptr;
    logic [PW-1:0]            rd_ptr;

    logic issue;
    logic push;
    logic pop;
    logic fifo_empty;

    assign push       = vld_pipe[READ_LATENCY-1];
    assign fifo_empty = (fifo_count == '0);
    assign pop        = pixel_valid && pixel_ready;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            // NOTE: registers take non-blocking assignments, so every flop
            // samples pre-edge values no matter in which order the blocks run.
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first. Without one, a branch that
        // skips an assignment would infer a latch.
        state_nxt  = state;
        issue      = 1'b0;
        frame_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (frame_start) state_nxt = S_READ;
            end
            S_READ: begin
                issue = ({1'b0, fifo_count} + {1'b0, inflight}) < DEPTH_C;
                if (issue && x == X_LAST && y == Y_LAST) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (inflight == '0 && fifo_empty) begin
                    frame_done = 1'b1;
                    state_nxt  = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy           = (state != S_IDLE);
    assign fb_read_enable = issue;
    assign fb_read_addr   = issue ? addr : '0;

    // ------------------------------------------------------------------
    // Raster address / position counters and tag pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr     <= '0;
            x        <= '0;
            y        <= '0;
            vld_pipe <= '0;
            sof_pipe <= '0;
            eol_pipe <= '0;
            inflight <= '0;
        end else begin
            // Latch the base address here. Later buffer_sel changes are ignored.
            if (state == S_IDLE && frame_start) begin
                addr <= buffer_sel ? BUF1_BASE : '0;
                x    <= '0;
                y    <= '0;
            end else if (issue) begin
                addr <= addr + FB_ADDR_WIDTH'(1);
                if (x == X_LAST) begin
                    x <= '0;
                    y <= y + YW'(1);
                end else begin
                    x <= x + XW'(1);
                end
            end

            vld_pipe[0] <= issue;
            sof_pipe[0] <= (x == '0) && (y == '0);
            eol_pipe[0] <= (x == X_LAST);
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                sof_pipe[i] <= sof_pipe[i-1];
                eol_pipe[i] <= eol_pipe[i-1];
            end

            case ({issue, push})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
            if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // NOTE: the storage array has no reset. Entries are only read when
    // fifo_count says they are valid, so clearing the pointers is enough.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {sof_pipe[READ_LATENCY-1], eol_pipe[READ_LATENCY-1], fb_read_data};
    end

    // Force the outputs to zero while empty. Stale storage words never show.
    assign pixel_valid = !fifo_empty;
    assign {pixel_sof, pixel_eol, pixel_data} = pixel_valid ? fifo_mem[rd_ptr] : '0;

endmodule

// File: tb/tb_fb_scanout_reader.sv
// ---------------------------------------------------------------------------
// tb_fb_scanout_reader
//   Two instances on a 4x3 frame:
//     u_a: READ_LATENCY=1, FIFO_DEPTH=4
//     u_b: READ_LATENCY=3, FIFO_DEPTH=5
//   Each RAM model returns its own address (RAM[a] = a) after the instance's
//   latency. The bench drives inputs and samples outputs on the falling edge.
// ---------------------------------------------------------------------------
module tb_fb_scanout_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        fs_a = 1'b0, sel_a = 1'b0, pr_a = 1'b1;
    logic [15:0] addr_a;
    logic        en_a, pv_a, sof_a, eol_a, busy_a, done_a;
    logic [11:0] rdata_a = '0, pd_a;

    logic        fs_b = 1'b0, sel_b = 1'b0, pr_b = 1'b1;
    logic [15:0] addr_b;
    logic        en_b, pv_b, sof_b, eol_b, busy_b, done_b;
    logic [11:0] pd_b;
    logic [15:0] ram_b1 = '0, ram_b2 = '0, ram_b3 = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fb_scanout_reader #(
        .FB_WIDTH(4), .FB_HEIGHT(3), .FB_ADDR_WIDTH(16), .COLOR_WIDTH(12),
        .READ_LATENCY(1), .FIFO_DEPTH(4)
    ) u_a (
        .clk(clk), .rst(rst), .frame_start(fs_a), .buffer_sel(sel_a),
        .fb_read_addr(addr_a), .fb_read_enable(en_a), .fb_read_data(rdata_a),
        .pixel_data(pd_a), .pixel_valid(pv_a), .pixel_ready(pr_a),
        .pixel_sof(sof_a), .pixel_eol(eol_a), .busy(busy_a), .frame_done(done_a)
    );

    fb_scanout_reader #(
        .FB_WIDTH(4), .FB_HEIGHT(3), .FB_ADDR_WIDTH(16), .COLOR_WIDTH(12),
        .READ_LATENCY(3), .FIFO_DEPTH(5)
    ) u_b (
        .clk(clk), .rst(rst), .frame_start(fs_b), .buffer_sel(sel_b),
        .fb_read_addr(addr_b), .fb_read_enable(en_b), .fb_read_data(ram_b3[11:0]),
        .pixel_data(pd_b), .pixel_valid(pv_b), .pixel_ready(pr_b),
        .pixel_sof(sof_b), .pixel_eol(eol_b), .busy(busy_b), .frame_done(done_b)
    );

    // RAM models: the data word equals the address.
    always @(posedge clk) begin
        rdata_a <= addr_a[11:0];
        ram_b1  <= addr_b;
        ram_b2  <= ram_b1;
        ram_b3  <= ram_b2;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One frame on u_a. Cycle c counts from the frame_start edge (c=1 is the
    // first cycle in READ). Ready is low in cycles stall_lo..stall_hi. When
    // poke is set, buffer_sel toggles every cycle and frame_start pulses in
    // cycle 5.
    task automatic frame_a(input logic sel, input int stall_lo, input int stall_hi,
                           input bit poke, input string nm);
        int          px       = 0;
        int          strobes  = 0;
        int          pops     = 0;
        int          max_out  = 0;
        int          done_cnt = 0;
        int          done_cyc = -1;
        int          last_hs  = -1;
        int          first_v  = -1;
        int          base     = sel ? 12 : 0;
        bit          was_stall = 1'b0;
        logic [13:0] held     = '0;

        @(negedge clk);
        sel_a = sel;
        fs_a  = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            fs_a = poke && (c == 5);
            if (poke) sel_a = ~sel_a;
            pr_a = !(c >= stall_lo && c <= stall_hi);
            if (c == 1) begin
                check({nm, "_first_strobe"}, {31'd0, en_a}, 1);
                check({nm, "_first_addr"}, {16'd0, addr_a}, base);
                check({nm, "_busy"}, {31'd0, busy_a}, 1);
            end
            if (en_a) strobes++;
            if (strobes - pops > max_out) max_out = strobes - pops;
            if (was_stall) check({nm, "_stall_hold"}, {17'd0, pv_a, sof_a, eol_a, pd_a}, {17'd1, held});
            was_stall = pv_a && !pr_a;
            held      = {sof_a, eol_a, pd_a};
            if (pv_a && first_v < 0) first_v = c;
            if (pv_a && pr_a) begin
                check({nm, "_data"}, {20'd0, pd_a}, base + px);
                check({nm, "_sof"}, {31'd0, sof_a}, (px == 0) ? 1 : 0);
                check({nm, "_eol"}, {31'd0, eol_a}, (px % 4 == 3) ? 1 : 0);
                if (stall_hi < 0) check({nm, "_px_cycle"}, c, 3 + px);
                pops++;
                px++;
                last_hs = c;
            end
            if (done_a) begin
                done_cnt++;
                done_cyc = c;
            end
            if (done_cnt > 0 && c > done_cyc + 3) break;
        end
        fs_a = 1'b0;
        pr_a = 1'b1;
        check({nm, "_first_valid_cycle"}, first_v, 3);
        check({nm, "_pixel_count"}, px, 12);
        check({nm, "_done_count"}, done_cnt, 1);
        check({nm, "_done_cycle"}, done_cyc, last_hs + 1);
        check({nm, "_idle_after"}, {31'd0, busy_a}, 0);
        check({nm, "_credit_bound"}, (max_out <= 4) ? 1 : 0, 1);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("reset_a_outputs", {9'd0, addr_a, en_a, pd_a, pv_a, sof_a, eol_a, busy_a, done_a}, 0);
        check("reset_b_outputs", {9'd0, addr_b, en_b, pd_b, pv_b, sof_b, eol_b, busy_b, done_b}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Full-rate frames from each buffer; mid-frame buffer_sel / frame_start pokes
        frame_a(1'b0, -1, -1, 1'b0, "sel0");
        frame_a(1'b1, -1, -1, 1'b1, "sel1_poke");
        frame_a(1'b0, -1, -1, 1'b1, "sel0_poke");

        // Backpressure: ready low in cycles 3..10
        frame_a(1'b0, 3, 10, 1'b0, "stall");

        // Reset mid-frame after pixel 5 has transferred
        begin
            int px = 0;
            int dn = 0;
            @(negedge clk);
            sel_a = 1'b0;
            fs_a  = 1'b1;
            for (int c = 1; c <= 40; c++) begin
                @(negedge clk);
                fs_a = 1'b0;
                pr_a = 1'b1;
                if (done_a) dn++;
                if (pv_a && pr_a) begin
                    check("pre_rst_data", {20'd0, pd_a}, px);
                    px++;
                end
                if (px == 6) break;
            end
            check("pre_rst_px", px, 6);
            @(negedge clk);
            rst = 1'b1;
            #1;
            check("rst_outputs", {9'd0, addr_a, en_a, pd_a, pv_a, sof_a, eol_a, busy_a, done_a}, 0);
            @(negedge clk);
            check("rst_held_outputs", {9'd0, addr_a, en_a, pd_a, pv_a, sof_a, eol_a, busy_a, done_a}, 0);
            rst = 1'b0;
            check("rst_no_done", dn, 0);
        end
        frame_a(1'b0, -1, -1, 1'b0, "after_rst");

        // Longer latency, deeper FIFO, random ready
        begin
            int px = 0, strobes = 0, pops = 0, max_out = 0, dn = 0, first_v = -1;
            @(negedge clk);
            sel_b = 1'b0;
            fs_b  = 1'b1;
            for (int c = 1; c <= 400; c++) begin
                @(negedge clk);
                fs_b = 1'b0;
                pr_b = 1'($urandom_range(0, 1));
                if (en_b) strobes++;
                if (strobes - pops > max_out) max_out = strobes - pops;
                if (pv_b && first_v < 0) first_v = c;
                if (pv_b && pr_b) begin
                    check("b_data", {20'd0, pd_b}, px);
                    check("b_sof", {31'd0, sof_b}, (px == 0) ? 1 : 0);
                    check("b_eol", {31'd0, eol_b}, (px % 4 == 3) ? 1 : 0);
                    pops++;
                    px++;
                end
                if (done_b) dn++;
                if (dn > 0 && !busy_b) break;
            end
            pr_b = 1'b1;
            check("b_first_valid_cycle", first_v, 5);
            check("b_pixel_count", px, 12);
            check("b_done_count", dn, 1);
            check("b_credit_bound", (max_out <= 5) ? 1 : 0, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
